tv_player: RTL and testbench

Hardware test-vector player: the read side of the random-test-generation flow. It fetches stored test vectors, each with its golden response, from a vector memory. It applies each vector to the circuit under test (CUT), samples the CUT response after a settle interval, and compares it with the golden response. It reports pass/fail, a mismatch count, the first failing index, and a MISR signature of all responses. It sits between the vector memory (loaded from the generated `.tst` content) and the CUT input/output pins.

---
 rtl/tv_pkg.sv | 23 ++
 rtl/tv_misr.sv | 42 ++++
 rtl/tv_player.sv | 180 ++++++++++++++++++
 tb/tb_tv_player.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv_pkg.sv
// Shared types, default widths and the MISR step used by the vector player.
package tv_pkg;

  localparam int TV_IN_W  = 33;
  localparam int TV_OUT_W = 25;
  localparam logic [TV_OUT_W-1:0] TV_MISR_POLY = 25'h1000009;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_APPLY,
    S_COMPARE,
    S_FINISH
  } tv_state_t;

  // One MISR step: shift left, fold the dropped MSB back through the taps, absorb the response.
  function automatic logic [TV_OUT_W-1:0] misr_next(input logic [TV_OUT_W-1:0] sig,
                                                    input logic [TV_OUT_W-1:0] resp);
    misr_next = {sig[TV_OUT_W-2:0], 1'b0} ^ (sig[TV_OUT_W-1] ? TV_MISR_POLY : '0) ^ resp;
  endfunction

endpackage

// File: rtl/tv_misr.sv
// Multiple-input signature register compacting every sampled CUT response of a run.
module tv_misr
  import tv_pkg::*;
#(
  parameter int               OUT_W = TV_OUT_W,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(TV_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W-1:0] sig
);

  logic [OUT_W-1:0] sig_q;
  logic [OUT_W-1:0] sig_d;

  // The package step is reused when the geometry matches its defaults; otherwise the same
  // recurrence is built for the configured width and taps.
  generate
    if (OUT_W == TV_OUT_W && POLY == OUT_W'(TV_MISR_POLY)) begin : g_pkg_step
      // Next signature from the shared helper.
      always_comb sig_d = misr_next(sig_q, resp);
    end else begin : g_gen_step
      // Next signature for a non-default width or polynomial.
      always_comb sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ resp;
    end
  endgenerate

  // Clear wins over enable so a run start always begins from a zero signature.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/tv_player.sv
// Test-vector player: fetches {vector, golden} pairs, drives the CUT, waits a settle
// interval, samples and compares the response, and compacts all responses into a MISR.
//
// Memory handshake: mem_rd is a single-cycle request carrying mem_addr; the memory answers
// with exactly one mem_valid/mem_data beat at least one cycle later. Only WAIT_MEM accepts
// that beat; a beat arriving in any other state (including after a reset abort) is dropped.
module tv_player
  import tv_pkg::*;
#(
  parameter int               IN_W      = TV_IN_W,
  parameter int               OUT_W     = TV_OUT_W,
  parameter int               DEPTH     = 64,
  parameter int               ADDR_W    = $clog2(DEPTH),
  parameter int               SETTLE    = 3,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(TV_MISR_POLY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_vec,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_valid,
  input  logic [IN_W+OUT_W-1:0] mem_data,
  output logic [IN_W-1:0]       cut_in,
  input  logic [OUT_W-1:0]      cut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_W:0]       fail_count,
  output logic [ADDR_W-1:0]     first_fail_idx,
  output logic [OUT_W-1:0]      signature
);

  // Settle counter is loaded with SETTLE-1 and counts down to zero.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

  tv_state_t          state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W:0]    n_q;
  logic [CNT_W-1:0]   settle_q;
  logic [OUT_W-1:0]   gold_q;
  logic [OUT_W-1:0]   resp_q;
  logic [IN_W-1:0]    cut_in_q;
  logic               mem_rd_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               busy_q;
  logic               done_q;
  logic               fail_q;
  logic [ADDR_W:0]    fail_count_q;
  logic [ADDR_W-1:0]  first_fail_q;

  logic [ADDR_W:0]    n_clamp;
  logic               last_vec;
  logic               misr_clr;
  logic               misr_en;

  // Requested vector count limited to the memory depth.
  always_comb n_clamp = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;

  // Current vector is the final one of the run.
  always_comb last_vec = ({1'b0, idx_q} == (n_q - 1'b1));

  // MISR is cleared on every accepted start and advanced once per COMPARE.
  always_comb begin
    misr_clr = (state_q == S_IDLE) && start;
    misr_en  = (state_q == S_COMPARE);
  end

  // Run sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      settle_q     <= '0;
      gold_q       <= '0;
      resp_q       <= '0;
      cut_in_q     <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            idx_q        <= '0;
            n_q          <= n_clamp;
            busy_q       <= 1'b1;
            if (n_clamp == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (mem_valid) begin
            cut_in_q <= mem_data[IN_W+OUT_W-1:OUT_W];
            gold_q   <= mem_data[OUT_W-1:0];
            settle_q <= CNT_W'(SETTLE - 1);
            state_q  <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (settle_q == '0) begin
            resp_q  <= cut_out;
            state_q <= S_COMPARE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_COMPARE: begin
          if (resp_q != gold_q) begin
            fail_count_q <= fail_count_q + 1'b1;
            fail_q       <= 1'b1;
            if (!fail_q) begin
              first_fail_q <= idx_q;
            end
          end
          if (last_vec) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= idx_q + 1'b1;
            state_q    <= S_FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= idx_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  tv_misr #(
    .OUT_W (OUT_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (misr_clr),
    .en   (misr_en),
    .resp (resp_q),
    .sig  (signature)
  );

  assign mem_rd         = mem_rd_q;
  assign mem_addr       = mem_addr_q;
  assign cut_in         = cut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_tv_player.sv
// Bench for tv_player: behavioural memory with variable latency, a pipelined CUT model,
// a run-level reference model and an address scoreboard.
module tb_tv_player;

  localparam int IN_W   = 33;
  localparam int OUT_W  = 25;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [OUT_W-1:0] POLY = 25'h1000009;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W:0]       num_vec;
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_valid;
  logic [IN_W+OUT_W-1:0] mem_data;
  logic [IN_W-1:0]       cut_in;
  logic [OUT_W-1:0]      cut_out;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_W:0]       fail_count;
  logic [ADDR_W-1:0]     first_fail_idx;
  logic [OUT_W-1:0]      signature;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  tv_player dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vec        (num_vec),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data),
    .cut_in         (cut_in),
    .cut_out        (cut_out),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .signature      (signature)
  );

  // ---------------- CUT model ----------------
  function automatic logic [OUT_W-1:0] cut_fn(input logic [IN_W-1:0] v);
    return v[OUT_W-1:0] ^ {17'b0, v[IN_W-1:OUT_W]};
  endfunction

  // The CUT output lags its input by two register stages, so only a response sampled
  // exactly three edges after cut_in changes reflects the current vector.
  logic [IN_W-1:0] cut_d1 = '0;
  logic [IN_W-1:0] cut_d2 = '0;
  always @(posedge clk) begin
    cut_d1 <= cut_in;
    cut_d2 <= cut_d1;
  end
  assign cut_out = cut_fn(cut_d2);

  // ---------------- vector memory model ----------------
  logic [IN_W-1:0]       vec_m  [DEPTH];
  logic [OUT_W-1:0]      gold_m [DEPTH];
  int                    lat_mode;
  int                    pend;
  logic [ADDR_W-1:0]     pend_addr;
  logic                  mv_mem, mv_inj;
  logic [IN_W+OUT_W-1:0] md_mem, md_inj;

  assign mem_valid = mv_mem | mv_inj;
  assign mem_data  = mv_inj ? md_inj : md_mem;

  initial begin
    mv_mem = 1'b0;
    md_mem = '0;
    pend   = 0;
    forever begin
      @(negedge clk);
      mv_mem = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mv_mem = 1'b1;
          md_mem = {vec_m[pend_addr], gold_m[pend_addr]};
        end
      end
      if (!rst && mem_rd) begin
        pend_addr = mem_addr;
        pend      = (lat_mode == 0) ? 1 : int'($urandom_range(1, 5));
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [ADDR_W-1:0] exp_q[$];
  logic              exp_fail;
  logic [ADDR_W:0]   exp_cnt;
  logic [ADDR_W-1:0] exp_ffi;
  logic [OUT_W-1:0]  exp_sig;
  logic [IN_W-1:0]   exp_cut_in;
  bit                in_run;
  bit                res_valid;

  // Signature as a GF(2) polynomial: multiply by x, reduce modulo x^25 + taps, add response.
  function automatic logic [OUT_W-1:0] misr_model(input logic [OUT_W-1:0] s,
                                                  input logic [OUT_W-1:0] r);
    logic [OUT_W:0] wide;
    wide = {s, 1'b0};
    if (wide[OUT_W]) wide = wide ^ {1'b1, POLY};
    return wide[OUT_W-1:0] ^ r;
  endfunction

  task automatic build_model(input int nreq);
    int n;
    logic [OUT_W-1:0] r;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    exp_fail = 1'b0;
    exp_cnt  = '0;
    exp_ffi  = '0;
    exp_sig  = '0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      r = cut_fn(vec_m[i]);
      exp_q.push_back(ADDR_W'(i));
      if (r != gold_m[i]) begin
        if (!exp_fail) exp_ffi = ADDR_W'(i);
        exp_fail = 1'b1;
        exp_cnt  = exp_cnt + 1'b1;
      end
      exp_sig = misr_model(exp_sig, r);
    end
    if (n > 0) exp_cut_in = vec_m[n-1];
  endtask

  task automatic set_cleared();
    exp_fail   = 1'b0;
    exp_cnt    = '0;
    exp_ffi    = '0;
    exp_sig    = '0;
    exp_cut_in = '0;
    exp_q.delete();
  endtask

  // Compare process: address order of every read, busy during runs, result stability at rest.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rd) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_rd_unexpected: read of addr %0d, none expected", mem_addr);
          end else begin
            chk("mem_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
          end
        end
        if (in_run) chk("busy_in_run", 64'(busy), 64'd1);
        if (res_valid && !in_run) begin
          chk("fail", 64'(fail), 64'(exp_fail));
          chk("fail_count", 64'(fail_count), 64'(exp_cnt));
          chk("first_fail_idx", 64'(first_fail_idx), 64'(exp_ffi));
          chk("signature", 64'(signature), 64'(exp_sig));
          chk("cut_in_hold", 64'(cut_in), 64'(exp_cut_in));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_random(input int corrupt_div);
    for (int i = 0; i < DEPTH; i++) begin
      vec_m[i]  = IN_W'({$urandom(), $urandom()});
      gold_m[i] = cut_fn(vec_m[i]);
      if (corrupt_div > 0 && $urandom_range(0, corrupt_div - 1) == 0)
        gold_m[i] = gold_m[i] ^ (OUT_W'(1) << $urandom_range(0, OUT_W - 1));
    end
  endtask

  // Called at the negedge right after the start-accepting edge; returns at the done negedge.
  // done is expected 6*n edges after that edge, i.e. 6*n+2 cycles counting start and FINISH.
  task automatic wait_done(input int n, input bit check_time);
    int cyc;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    in_run = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end else if (check_time) begin
      chk("done_latency", 64'(cyc), 64'(6 * n));
    end
    chk("reads_all_issued", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input int nreq, input bit check_time);
    int n;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    build_model(nreq);
    num_vec   = (ADDR_W+1)'(nreq);
    res_valid = 0;
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    in_run = 1;
    wait_done(n, check_time);
    res_valid = 1;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_run", 64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  logic [OUT_W-1:0] sig1;
  int               guard;

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0;
    mv_inj = 1'b0; md_inj = '0; lat_mode = 0;
    in_run = 0; res_valid = 0;
    set_cleared();
    for (int i = 0; i < DEPTH; i++) begin
      vec_m[i]  = '0;
      gold_m[i] = '0;
    end
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_cut_in", 64'(cut_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_fail_count", 64'(fail_count), 64'd0);
    chk("rst_first_fail", 64'(first_fail_idx), 64'd0);
    chk("rst_signature", 64'(signature), 64'd0);
    rst = 1'b0;
    res_valid = 1;
    @(negedge clk);

    // hand-computed signature: responses 25'h1000000 then 0 give 25'h1000009
    vec_m[0] = 33'h001000000; gold_m[0] = 25'h1000000;
    vec_m[1] = 33'h000000000; gold_m[1] = 25'h0000000;
    run(2, 1);
    chk("lit_sig_2vec", 64'(signature), 64'h1000009);
    chk("lit_fail_2vec", 64'(fail), 64'd0);

    // four matching vectors, unit latency
    fill_random(0);
    run(4, 1);
    chk("lit_fail_4vec", 64'(fail), 64'd0);
    chk("lit_count_4vec", 64'(fail_count), 64'd0);

    // golden corrupted at indices 2 and 5 of 8
    fill_random(0);
    gold_m[2] = gold_m[2] ^ 25'h0000001;
    gold_m[5] = gold_m[5] ^ 25'h1400000;
    run(8, 1);
    chk("lit_fail_8vec", 64'(fail), 64'd1);
    chk("lit_count_8vec", 64'(fail_count), 64'd2);
    chk("lit_ffi_8vec", 64'(first_fail_idx), 64'd2);

    // empty run: no reads, results cleared, cut_in keeps the last vector
    run(0, 1);
    chk("lit_count_0vec", 64'(fail_count), 64'd0);
    chk("lit_sig_0vec", 64'(signature), 64'd0);

    // oversize request with random memory latency clamps to the full depth
    lat_mode = 1;
    fill_random(8);
    run(80, 0);
    lat_mode = 0;

    // reset during APPLY of vector 3, then a stray mem_valid
    fill_random(0);
    build_model(8);
    num_vec = 7'd8; res_valid = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_run = 1;
    guard = 0;
    while (!(mem_rd && mem_addr == 6'd3) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_vec3", 64'(mem_rd && mem_addr == 6'd3), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1; in_run = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_cleared();
    res_valid = 1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    md_inj = {IN_W'({$urandom(), $urandom()}), OUT_W'($urandom())};
    mv_inj = 1'b1;
    @(negedge clk);
    mv_inj = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_valid_busy", 64'(busy), 64'd0);
    chk("late_valid_cut_in", 64'(cut_in), 64'd0);
    fill_random(4);
    run(12, 1);

    // start pulse while busy is ignored; start held through FINISH re-triggers
    fill_random(4);
    build_model(5);
    num_vec = 7'd5; res_valid = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_run = 1;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    wait_done(3, 0);
    chk("run1_fail", 64'(fail), 64'(exp_fail));
    chk("run1_count", 64'(fail_count), 64'(exp_cnt));
    chk("run1_ffi", 64'(first_fail_idx), 64'(exp_ffi));
    chk("run1_sig", 64'(signature), 64'(exp_sig));
    sig1 = exp_sig;
    num_vec = 7'd7;
    build_model(7);
    @(negedge clk);
    chk("retrig_idle_busy", 64'(busy), 64'd0);
    chk("retrig_idle_sig", 64'(signature), 64'(sig1));
    @(negedge clk);
    chk("retrig_busy", 64'(busy), 64'd1);
    chk("retrig_cleared_count", 64'(fail_count), 64'd0);
    chk("retrig_cleared_sig", 64'(signature), 64'd0);
    chk("retrig_mem_rd", 64'(mem_rd), 64'd1);
    start = 1'b0; in_run = 1;
    wait_done(7, 1);
    res_valid = 1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
